// File: rtl/pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_controller
// Brief    : Match sequencer for the two-player paddle game. Gates paddle
//            motion, holds/serves/runs the ball, keeps both scores and
//            declares the winner. Optional pause support is compiled in when
//            the macro PONG_PAUSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pong_match_controller #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 50,
    parameter int POINT_DELAY = 100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic                           start,
    input  logic                           miss_left,
    input  logic                           miss_right,
    input  logic                           pause,
    output logic                           paddle_hold,
    output logic                           ball_rst,
    output logic                           ball_run,
    output logic                           serve_dir,
    output logic [$clog2(WIN_SCORE+1)-1:0] score1,
    output logic [$clog2(WIN_SCORE+1)-1:0] score2,
    output logic [2:0]                     state,
    output logic [1:0]                     winner
);

    localparam int c_SCORE_W   = $clog2(WIN_SCORE + 1);
    localparam int c_MAX_DELAY = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
    localparam int c_CNT_W     = $clog2(c_MAX_DELAY + 1);

    localparam logic [c_CNT_W-1:0]   c_SERVE_LAST = c_CNT_W'(SERVE_DELAY - 1);
    localparam logic [c_CNT_W-1:0]   c_POINT_LAST = c_CNT_W'(POINT_DELAY - 1);
    localparam logic [c_SCORE_W-1:0] c_WIN        = c_SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_POINT  = 3'd3,
        S_OVER   = 3'd4,
        S_PAUSED = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_next;
    logic [c_SCORE_W-1:0]   r_score1;
    logic [c_SCORE_W-1:0]   w_score1_next;
    logic [c_SCORE_W-1:0]   r_score2;
    logic [c_SCORE_W-1:0]   w_score2_next;
    logic                   r_serve_dir;
    logic                   w_serve_dir_next;
    logic [1:0]             r_winner;
    logic [1:0]             w_winner_next;
    logic                   r_paddle_hold;
    logic                   r_ball_rst;
    logic                   r_ball_run;
    logic                   w_paddle_hold_next;
    logic                   w_ball_rst_next;
    logic                   w_ball_run_next;

`ifndef PONG_PAUSE_EN
    // pause has no function in this build; kept only so the port list is fixed
    logic w_pause_unused;
    assign w_pause_unused = pause;
`endif

    // Next-state, counter, score and winner decisions for the match sequence
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_score1_next    = r_score1;
        w_score2_next    = r_score2;
        w_serve_dir_next = r_serve_dir;
        w_winner_next    = r_winner;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_state_next     = S_SERVE;
                    w_cnt_next       = '0;
                    w_score1_next    = '0;
                    w_score2_next    = '0;
                    w_winner_next    = 2'd0;
                    w_serve_dir_next = 1'b0;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    if (r_cnt == c_SERVE_LAST) begin
                        w_state_next = S_PLAY;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                // A double miss is a dead ball: no point awarded, serve side kept
                if (miss_left && miss_right) begin
                    w_state_next = S_POINT;
                end else if (miss_left) begin
                    if (r_score2 != c_WIN) begin
                        w_score2_next = r_score2 + 1'b1;
                    end
                    w_serve_dir_next = 1'b0;
                    w_state_next     = S_POINT;
                end else if (miss_right) begin
                    if (r_score1 != c_WIN) begin
                        w_score1_next = r_score1 + 1'b1;
                    end
                    w_serve_dir_next = 1'b1;
                    w_state_next     = S_POINT;
`ifdef PONG_PAUSE_EN
                end else if (pause) begin
                    // A miss in the same cycle takes precedence over pausing
                    w_state_next = S_PAUSED;
`endif
                end
            end
            S_POINT: begin
                if (tick) begin
                    if (r_cnt == c_POINT_LAST) begin
                        w_cnt_next = '0;
                        if (r_score1 == c_WIN) begin
                            w_state_next  = S_OVER;
                            w_winner_next = 2'd1;
                        end else if (r_score2 == c_WIN) begin
                            w_state_next  = S_OVER;
                            w_winner_next = 2'd2;
                        end else begin
                            w_state_next = S_SERVE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
`ifdef PONG_PAUSE_EN
            S_PAUSED: begin
                if (pause) begin
                    w_state_next = S_PLAY;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs change on the causing edge
    always_comb begin
        w_paddle_hold_next = 1'b1;
        w_ball_rst_next    = 1'b1;
        w_ball_run_next    = 1'b0;
        case (w_state_next)
            S_SERVE:  begin w_paddle_hold_next = 1'b0; w_ball_rst_next = 1'b1; w_ball_run_next = 1'b0; end
            S_PLAY:   begin w_paddle_hold_next = 1'b0; w_ball_rst_next = 1'b0; w_ball_run_next = 1'b1; end
            S_POINT:  begin w_paddle_hold_next = 1'b1; w_ball_rst_next = 1'b0; w_ball_run_next = 1'b0; end
            S_PAUSED: begin w_paddle_hold_next = 1'b1; w_ball_rst_next = 1'b0; w_ball_run_next = 1'b0; end
            default:  begin w_paddle_hold_next = 1'b1; w_ball_rst_next = 1'b1; w_ball_run_next = 1'b0; end
        endcase
    end

    // State, match bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_score1      <= '0;
            r_score2      <= '0;
            r_serve_dir   <= 1'b0;
            r_winner      <= 2'd0;
            r_paddle_hold <= 1'b1;
            r_ball_rst    <= 1'b1;
            r_ball_run    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_score1      <= w_score1_next;
            r_score2      <= w_score2_next;
            r_serve_dir   <= w_serve_dir_next;
            r_winner      <= w_winner_next;
            r_paddle_hold <= w_paddle_hold_next;
            r_ball_rst    <= w_ball_rst_next;
            r_ball_run    <= w_ball_run_next;
        end
    end

    assign paddle_hold = r_paddle_hold;
    assign ball_rst    = r_ball_rst;
    assign ball_run    = r_ball_run;
    assign serve_dir   = r_serve_dir;
    assign score1      = r_score1;
    assign score2      = r_score2;
    assign state       = r_state;
    assign winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_match_controller
// Brief    : Scoreboard bench for pong_match_controller. A stimulus process
//            drives directed then random pulses and pushes the reference
//            model's expected outputs; a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_match_controller;

    localparam int WIN_SCORE   = 3;
    localparam int SERVE_DELAY = 2;
    localparam int POINT_DELAY = 2;
    localparam int SW          = $clog2(WIN_SCORE + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          miss_left = 1'b0;
    logic          miss_right = 1'b0;
    logic          pause = 1'b0;
    logic          paddle_hold;
    logic          ball_rst;
    logic          ball_run;
    logic          serve_dir;
    logic [SW-1:0] score1;
    logic [SW-1:0] score2;
    logic [2:0]    state;
    logic [1:0]    winner;

    pong_match_controller #(
        .WIN_SCORE  (WIN_SCORE),
        .SERVE_DELAY(SERVE_DELAY),
        .POINT_DELAY(POINT_DELAY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .pause      (pause),
        .paddle_hold(paddle_hold),
        .ball_rst   (ball_rst),
        .ball_run   (ball_run),
        .serve_dir  (serve_dir),
        .score1     (score1),
        .score2     (score2),
        .state      (state),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       hold;
        logic       brst;
        logic       run;
        logic       dir;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: phase names by meaning, a count of ticks seen in the
    // current timed phase, and the game facts.
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4, P_PAUSED = 5;
    int m_phase, m_ticks, m_s1, m_s2, m_win, m_dir;

    // Per-phase paddle_hold / ball_rst / ball_run table
    int hold_tbl [6] = '{1, 0, 0, 1, 1, 1};
    int brst_tbl [6] = '{1, 1, 0, 0, 1, 0};
    int run_tbl  [6] = '{0, 0, 1, 0, 0, 0};

    function automatic obs_t model_obs();
        obs_t o;
        o.st   = 3'(m_phase);
        o.hold = 1'(hold_tbl[m_phase]);
        o.brst = 1'(brst_tbl[m_phase]);
        o.run  = 1'(run_tbl[m_phase]);
        o.dir  = 1'(m_dir);
        o.s1   = 4'(m_s1);
        o.s2   = 4'(m_s2);
        o.win  = 2'(m_win);
        return o;
    endfunction

    task automatic model_update(input bit r, input bit t, input bit s, input bit ml,
                                input bit mr, input bit p);
        bool_pause: begin end
        if (r) begin
            m_phase = P_IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
            return;
        end
        if ((m_phase == P_IDLE || m_phase == P_OVER) && s) begin
            m_phase = P_SERVE; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
        end else if (m_phase == P_SERVE && t) begin
            m_ticks++;
            if (m_ticks == SERVE_DELAY) begin m_phase = P_PLAY; m_ticks = 0; end
        end else if (m_phase == P_PLAY) begin
            if (ml && mr) m_phase = P_POINT;
            else if (ml) begin m_s2 = (m_s2 + 1 > WIN_SCORE) ? WIN_SCORE : m_s2 + 1; m_dir = 0; m_phase = P_POINT; end
            else if (mr) begin m_s1 = (m_s1 + 1 > WIN_SCORE) ? WIN_SCORE : m_s1 + 1; m_dir = 1; m_phase = P_POINT; end
`ifdef PONG_PAUSE_EN
            else if (p) m_phase = P_PAUSED;
`endif
        end else if (m_phase == P_POINT && t) begin
            m_ticks++;
            if (m_ticks == POINT_DELAY) begin
                m_ticks = 0;
                if (m_s1 == WIN_SCORE) begin m_phase = P_OVER; m_win = 1; end
                else if (m_s2 == WIN_SCORE) begin m_phase = P_OVER; m_win = 2; end
                else m_phase = P_SERVE;
            end
        end else if (m_phase == P_PAUSED && p) begin
            m_phase = P_PLAY;
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge
    task automatic step(input bit r, input bit t, input bit s, input bit ml,
                        input bit mr, input bit p);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; tick = t; start = s; miss_left = ml; miss_right = mr; pause = p;
        model_update(r, t, s, ml, mr, p);
        e.cyc = cyc + 1;
        e.o   = model_obs();
        q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
    endtask

    // Monitor: compare every cycle that has an expectation due
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                a.st = state; a.hold = paddle_hold; a.brst = ball_rst; a.run = ball_run;
                a.dir = serve_dir; a.s1 = 4'(score1); a.s2 = 4'(score2); a.win = winner;
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d actual st=%0d hold=%0b brst=%0b run=%0b dir=%0b s1=%0d s2=%0d win=%0d required st=%0d hold=%0b brst=%0b run=%0b dir=%0b s1=%0d s2=%0d win=%0d",
                             e.cyc, a.st, a.hold, a.brst, a.run, a.dir, a.s1, a.s2, a.win,
                             e.o.st, e.o.hold, e.o.brst, e.o.run, e.o.dir, e.o.s1, e.o.s2, e.o.win);
                end
            end
        end
    end

    // Stimulus: directed walk through the match flow, then random pulses
    initial begin
        m_phase = P_IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        step(0, 1, 1, 0, 0, 0);           // start, entry tick not counted
        ticks(2);                         // to PLAY
        step(0, 0, 0, 0, 1, 0);           // miss_right -> score1
        ticks(2);                         // back to SERVE
        ticks(2);                         // PLAY
        step(0, 0, 0, 1, 1, 0);           // double miss
        ticks(4);
        for (int k = 0; k < 3; k++) begin // three points to player 2
            step(0, 0, 0, 1, 0, 0);
            step(0, 0, 0, 1, 1, 0);       // ignored in POINT
            ticks(2);
            if (k < 2) ticks(2);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);           // restart from OVER
        step(0, 0, 0, 1, 1, 0);           // misses in SERVE ignored
        step(0, 0, 1, 0, 0, 0);           // start in SERVE ignored
        step(0, 1, 0, 0, 0, 0);           // counter at 1
        step(1, 1, 0, 0, 0, 0);           // reset mid-count
        step(0, 1, 1, 0, 0, 0);
        ticks(2);
        step(0, 0, 0, 0, 0, 1);           // pause in PLAY
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
